// File: rtl/elevator_pkg.sv
// Shared elevator types and default timing constants.
package elevator_pkg;

   typedef enum logic [1:0] {
      Closed     = 2'd0,
      Open       = 2'd1,
      Overweight = 2'd2,
      Closing    = 2'd3
   } door_state_t;

   localparam int unsigned DefOpenTicks  = 5;
   localparam int unsigned DefCloseTicks = 2;
   localparam int unsigned DefSyncStages = 2;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module sync_ff #(
   parameter int unsigned Depth = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [Depth-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < Depth; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/door_controller.sv
// Elevator car door FSM with tick-based open/close timing and overweight hold.
// Define ALARM_BLINK_EN to make the overweight alarm toggle on every tick.
module door_controller
   import elevator_pkg::*;
#(
   parameter int unsigned OpenTicks  = DefOpenTicks,
   parameter int unsigned CloseTicks = DefCloseTicks,
   parameter int unsigned SyncStages = DefSyncStages
) (
   input  logic clock_i,
   input  logic reset_ni,
   input  logic tick_i,
   input  logic arrived_i,
   input  logic button_open_i,
   input  logic button_close_i,
   input  logic obstruction_i,
   input  logic weight_limit_exceeded_i,
   output logic door_o,
   output logic door_closing_o,
   output logic move_permit_o,
   output logic overweight_alarm_o
);

   localparam int unsigned MaxTicks = (OpenTicks > CloseTicks) ? OpenTicks : CloseTicks;
   localparam int unsigned TimerW   = $clog2(MaxTicks + 1);

   door_state_t       state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              door_q, door_d;
   logic              closing_q, closing_d;
   logic              permit_q, permit_d;
   logic              alarm_q, alarm_d;
   logic              ow, obs;

   sync_ff #(.Depth(SyncStages)) u_sync_ow (
      .clk_i  (clock_i),
      .rst_ni (reset_ni),
      .d_i    (weight_limit_exceeded_i),
      .q_o    (ow)
   );

   sync_ff #(.Depth(SyncStages)) u_sync_obs (
      .clk_i  (clock_i),
      .rst_ni (reset_ni),
      .d_i    (obstruction_i),
      .q_o    (obs)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (tick_i && (timer_q != '0)) begin
         timer_d = timer_q - TimerW'(1);
      end
      unique case (state_q)
         Closed: begin
            if (arrived_i || button_open_i) begin
               state_d = Open;
               timer_d = TimerW'(OpenTicks);
            end
         end
         Open: begin
            if (button_open_i) begin
               timer_d = TimerW'(OpenTicks);
            end else if (tick_i && (timer_q == '0)) begin
               if (ow) begin
                  state_d = Overweight;
               end else begin
                  state_d = Closing;
                  timer_d = TimerW'(CloseTicks);
               end
            end else if (button_close_i) begin
               timer_d = '0;
            end
         end
         Overweight: begin
            timer_d = timer_q;
            if (!ow) begin
               state_d = Open;
               timer_d = TimerW'(OpenTicks);
            end
         end
         Closing: begin
            // Reopen requests beat expiry in the same cycle.
            if (obs || button_open_i || ow) begin
               state_d = Open;
               timer_d = TimerW'(OpenTicks);
            end else if (tick_i && (timer_q == '0)) begin
               state_d = Closed;
            end
         end
         default: begin
            state_d = Closed;
            timer_d = '0;
         end
      endcase
   end

   always_comb begin
      door_d    = (state_d != Closed);
      closing_d = (state_d == Closing);
      permit_d  = (state_d == Closed);
      alarm_d   = 1'b0;
      if (state_d == Overweight) begin
         if (state_q != Overweight) begin
            alarm_d = 1'b1;
         end else begin
`ifdef ALARM_BLINK_EN
            alarm_d = tick_i ? ~alarm_q : alarm_q;
`else
            alarm_d = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= Closed;
         timer_q   <= '0;
         door_q    <= 1'b0;
         closing_q <= 1'b0;
         permit_q  <= 1'b1;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         door_q    <= door_d;
         closing_q <= closing_d;
         permit_q  <= permit_d;
         alarm_q   <= alarm_d;
      end
   end

   assign door_o             = door_q;
   assign door_closing_o     = closing_q;
   assign move_permit_o      = permit_q;
   assign overweight_alarm_o = alarm_q;

endmodule
